// File: rtl/instr_stream_encoder_pkg.sv
// Shared constants for the instruction stream encoder: MIPS opcodes used by the
// control decoder, request kind codes and the loader state encoding.
package instr_stream_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_ORI   = 3'd1;
    localparam logic [2:0] KIND_LW    = 3'd2;
    localparam logic [2:0] KIND_SW    = 3'd3;
    localparam logic [2:0] KIND_BEQ   = 3'd4;
    localparam logic [2:0] KIND_J     = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_stream_encoder_pack.sv
// Combinational field packer: maps a request kind plus raw fields to a 32-bit
// MIPS word. Kinds 6/7 produce a zero word and raise the illegal flag.
module instr_field_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Opcode selection and field placement; immediates pass through unextended
    always_comb begin
        word_o    = 32'h0000_0000;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            KIND_ORI:   word_o = {OP_ORI, rs_i, rt_i, imm_i};
            KIND_LW:    word_o = {OP_LW, rs_i, rt_i, imm_i};
            KIND_SW:    word_o = {OP_SW, rs_i, rt_i, imm_i};
            KIND_BEQ:   word_o = {OP_BEQ, rs_i, rt_i, imm_i};
            KIND_J:     word_o = {OP_J, target_i};
            default: begin
                word_o    = 32'h0000_0000;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: accepts handshaked requests and writes encoded words
// sequentially into instruction memory. Optional ENC_ILLEGAL_CHECK_EN drops kinds 6/7.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              done_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              imem_we_o,
    output logic [ADDR_W+1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              full_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    enc_state_e        state_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W:0]   count_q;
    logic              we_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       data_q;

    logic [31:0]       word_s;
    logic [31:0]       data_d;
    logic              illegal_s;
    logic              accept_s;
    logic              write_s;
    logic              fill_s;

    instr_field_pack u_pack (
        .kind_i    (kind_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .rd_i      (rd_i),
        .shamt_i   (shamt_i),
        .funct_i   (funct_i),
        .imm_i     (imm_i),
        .target_i  (target_i),
        .word_o    (word_s),
        .illegal_o (illegal_s)
    );

    assign accept_s = valid_i && (state_q == ST_LOAD);
    assign fill_s   = write_s && (count_q == CNT_LAST);

`ifdef ENC_ILLEGAL_CHECK_EN
    logic err_q;

    assign write_s = accept_s && !illegal_s;
    assign data_d  = word_s;
    assign err_o   = err_q;

    // Sticky illegal-kind flag, cleared on every entry into LOAD
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (((state_q == ST_IDLE) && start_i) ||
                     ((state_q == ST_FULL) && start_i && !done_i)) begin
            err_q <= 1'b0;
        end else if (accept_s && illegal_s) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end
`else
    // Illegal kinds are written as a NOP word
    assign write_s = accept_s;
    assign data_d  = illegal_s ? 32'h0000_0000 : word_s;
    assign err_o   = 1'b0;
`endif

    // Loader FSM with counters and the registered write port
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            index_q <= {ADDR_W{1'b0}};
            count_q <= {(ADDR_W+1){1'b0}};
            we_q    <= 1'b0;
            addr_q  <= {(ADDR_W+2){1'b0}};
            data_q  <= 32'h0000_0000;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD;
                        index_q <= {ADDR_W{1'b0}};
                        count_q <= {(ADDR_W+1){1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (write_s) begin
                        we_q    <= 1'b1;
                        addr_q  <= {index_q, 2'b00};
                        data_q  <= data_d;
                        index_q <= index_q + IDX_ONE;
                        count_q <= count_q + CNT_ONE;
                    end else begin
                        we_q <= 1'b0;
                    end
                    // done outranks the filling beat
                    if (done_i) begin
                        state_q <= ST_IDLE;
                    end else if (fill_s) begin
                        state_q <= ST_FULL;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (done_i) begin
                        state_q <= ST_IDLE;
                    end else if (start_i) begin
                        state_q <= ST_LOAD;
                        index_q <= {ADDR_W{1'b0}};
                        count_q <= {(ADDR_W+1){1'b0}};
                    end else begin
                        state_q <= ST_FULL;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == ST_LOAD);
    assign busy_o      = (state_q != ST_IDLE);
    assign full_o      = (state_q == ST_FULL);
    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: directed scenarios with literal
// expectations, then randomized traffic compared cycle by cycle against a model.
module tb_instr_stream_encoder;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              start, done, valid;
    logic [2:0]        kind;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              ready_o, imem_we_o, busy_o, full_o, err_o;
    logic [ADDR_W+1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic [ADDR_W:0]   count_o;

    instr_stream_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .done_i(done),
        .valid_i(valid), .ready_o(ready_o), .kind_i(kind),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
        .imm_i(imm), .target_i(target), .imem_we_o(imem_we_o),
        .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .count_o(count_o), .busy_o(busy_o), .full_o(full_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: session mode (0 idle, 1 loading, 2 full), words written, next slot
    int          m_mode;
    int          m_cnt;
    int          m_idx;
    bit          m_err;
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;

    function automatic logic [31:0] enc(input logic [2:0] k);
        case (k)
            3'd0:    return {6'h00, rs, rt, rd, shamt, funct};
            3'd1:    return {6'h0D, rs, rt, imm};
            3'd2:    return {6'h23, rs, rt, imm};
            3'd3:    return {6'h2B, rs, rt, imm};
            3'd4:    return {6'h04, rs, rt, imm};
            3'd5:    return {6'h02, target};
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_idx = 0; m_err = 1'b0;
        e_we = 1'b0; e_addr = 32'h0; e_data = 32'h0;
    endtask

    task automatic open_session();
        m_mode = 1; m_cnt = 0; m_idx = 0; m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit illegal;
        e_we = 1'b0;
        illegal = (kind > 3'd5);
        if (m_mode == 0) begin
            if (start) open_session();
        end else if (m_mode == 1) begin
            if (valid) begin
`ifdef ENC_ILLEGAL_CHECK_EN
                if (illegal) m_err = 1'b1;
                else begin
                    e_we = 1'b1; e_addr = 32'(m_idx * 4); e_data = enc(kind);
                    m_idx = (m_idx + 1) % DEPTH; m_cnt++;
                end
`else
                e_we = 1'b1; e_addr = 32'(m_idx * 4); e_data = enc(kind);
                m_idx = (m_idx + 1) % DEPTH; m_cnt++;
`endif
            end
            if (done) m_mode = 0;
            else if (m_cnt == DEPTH) m_mode = 2;
        end else begin
            if (done) m_mode = 0;
            else if (start) open_session();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        chk("we",    32'(imem_we_o),   32'(e_we));
        chk("addr",  32'(imem_addr_o), e_addr);
        chk("data",  imem_data_o,      e_data);
        chk("count", 32'(count_o),     32'(m_cnt));
        chk("ready", 32'(ready_o),     32'(m_mode == 1));
        chk("busy",  32'(busy_o),      32'(m_mode != 0));
        chk("full",  32'(full_o),      32'(m_mode == 2));
        chk("err",   32'(err_o),       32'(m_err));
    endtask

    task automatic clr();
        start = 1'b0; done = 1'b0; valid = 1'b0; kind = 3'd0;
        rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; funct = 6'd0;
        imm = 16'h0; target = 26'h0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_fields();
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        shamt = 5'($urandom); funct = 6'($urandom);
        imm = 16'($urandom); target = 26'($urandom);
    endtask

    initial begin
        int r;
        clr();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        chk("rst_count", 32'(count_o), 32'd0);
        rst_n = 1'b1;

        // R-type add $3,$1,$2
        start = 1'b1; step(); clr();
        valid = 1'b1; kind = 3'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; funct = 6'h20;
        step(); clr();
        chk("rtype_we", 32'(imem_we_o), 32'd1);
        chk("rtype_addr", 32'(imem_addr_o), 32'h0);
        chk("rtype_data", imem_data_o, 32'h0022_1820);
        chk("rtype_count", 32'(count_o), 32'd1);
        step();
        chk("pulse_one_cycle", 32'(imem_we_o), 32'd0);

        // New session: lw then j back-to-back
        done = 1'b1; step(); clr();
        start = 1'b1; step(); clr();
        valid = 1'b1; kind = 3'd2; rt = 5'd8; imm = 16'h0004; step(); clr();
        chk("lw_data", imem_data_o, 32'h8C08_0004);
        chk("lw_addr", 32'(imem_addr_o), 32'h0);
        valid = 1'b1; kind = 3'd5; target = 26'h10; step(); clr();
        chk("j_data", imem_data_o, 32'h0800_0010);
        chk("j_addr", 32'(imem_addr_o), 32'h4);
        chk("j_we", 32'(imem_we_o), 32'd1);

        // ori accepted together with done
        valid = 1'b1; done = 1'b1; kind = 3'd1; rt = 5'd9; imm = 16'hFFFF; step(); clr();
        chk("ori_data", imem_data_o, 32'h3409_FFFF);
        chk("ori_busy", 32'(busy_o), 32'd0);

        // Illegal kind
        start = 1'b1; step(); clr();
        valid = 1'b1; kind = 3'd7; step(); clr();
`ifdef ENC_ILLEGAL_CHECK_EN
        chk("ill_we", 32'(imem_we_o), 32'd0);
        chk("ill_err", 32'(err_o), 32'd1);
        chk("ill_count", 32'(count_o), 32'd0);
`else
        chk("ill_we", 32'(imem_we_o), 32'd1);
        chk("ill_data", imem_data_o, 32'h0);
        chk("ill_count", 32'(count_o), 32'd1);
`endif
        done = 1'b1; step(); clr();

        // Fill to DEPTH, then a stalled beat
        start = 1'b1; step(); clr();
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields(); valid = 1'b1; kind = 3'($urandom_range(0, 5)); step();
        end
        clr();
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_ready", 32'(ready_o), 32'd0);
        chk("fill_count", 32'(count_o), 32'(DEPTH));
        chk("fill_last_addr", 32'(imem_addr_o), 32'((DEPTH - 1) * 4));
        valid = 1'b1; step(); clr();
        chk("stall_we", 32'(imem_we_o), 32'd0);
        chk("stall_count", 32'(count_o), 32'(DEPTH));
        done = 1'b1; step(); clr();
        chk("full_done_busy", 32'(busy_o), 32'd0);

        // Reset the cycle after an accept
        start = 1'b1; step(); clr();
        valid = 1'b1; kind = 3'd3; step(); clr();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_mid_we", 32'(imem_we_o), 32'd0);
        chk("rst_mid_count", 32'(count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 31));
            start = (r < 2) || (m_mode == 0 && r < 8);
            done  = (r == 31);
            valid = ($urandom_range(0, 9) < 7);
            kind  = 3'($urandom);
            rand_fields();
            step();
        end
        clr();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
